ps2_cmd_ctrl: RTL and testbench

Command sequencer that sits between the host logic and `ps2_core`. It serializes one- or two-byte device commands such as 0xED+LED mask, 0xF3+rate and 0xFF, and waits for the device acknowledge after each byte. It retries on resend or timeout and reports completion status. Bytes that are not ACK/resend responses are forwarded to the host as a scancode stream, so host logic never drives `ps2_core` directly.

---
 rtl/ps2_cmd_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: sequences 1/2-byte PS/2 device commands with ACK/resend/timeout handling
//   and forwards all other device bytes to the host as a scancode stream.
// Ports:
//   clk, rst (async active-low)
//   cmd_req/cmd_byte/cmd_has_arg/cmd_arg -> command in; cmd_ready out
//   cmd_done/cmd_err -> completion pulse and status (00 ok, 01 resend, 10 timeout)
//   hold_in -> host inhibit request, passed to core only while idle
//   rx_data/rx_parity_err/rx_vld -> forwarded device bytes
//   core_* -> connection to ps2_core
module ps2_cmd_ctrl #(
    parameter int CLK        = 50,
    parameter int TIMEOUT_MS = 20,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_ready,
    output logic       cmd_done,
    output logic [1:0] cmd_err,
    input  logic       hold_in,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_vld,
    output logic       core_send_req,
    output logic [7:0] core_send_data,
    output logic       core_hold_req,
    input  logic       core_idle,
    input  logic [7:0] core_rcv_data,
    input  logic       core_rcv_vld,
    input  logic       core_rcv_parity_err
);
    localparam int LIMIT = CLK * 1000 * TIMEOUT_MS;
    localparam int TW    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam int RW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(LIMIT - 1);
    localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic          has_arg_q, has_arg_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    arg_q, arg_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          send_req_q, send_req_d;
    logic          done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          rx_vld_q, rx_vld_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_perr_q, rx_perr_d;
    logic          is_ack, is_nak, is_tmo, fwd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            has_arg_q  <= 1'b0;
            cmd_q      <= '0;
            arg_q      <= '0;
            retry_q    <= '0;
            timer_q    <= '0;
            send_req_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            rx_vld_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            has_arg_q  <= has_arg_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            send_req_q <= send_req_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_vld_q   <= rx_vld_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        has_arg_d  = has_arg_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        retry_d    = retry_q;
        timer_d    = timer_q;
        send_req_d = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        is_ack     = core_rcv_vld && !core_rcv_parity_err && core_rcv_data == 8'hFA;
        is_nak     = core_rcv_vld && (core_rcv_parity_err || core_rcv_data == 8'hFE);
        // a byte arriving on the timeout cycle wins over the timeout
        is_tmo     = !core_rcv_vld && timer_q == T_LAST;
        // only ACK/resend responses inside WAIT are consumed; everything else reaches the host
        fwd        = core_rcv_vld && (state_q != WAIT || !(is_ack || is_nak));
        rx_vld_d   = fwd;
        rx_data_d  = fwd ? core_rcv_data : rx_data_q;
        rx_perr_d  = fwd ? core_rcv_parity_err : rx_perr_q;
        case (state_q)
            IDLE: begin
                if (cmd_req) begin
                    cmd_d     = cmd_byte;
                    arg_d     = cmd_arg;
                    has_arg_d = cmd_has_arg;
                    phase_d   = 1'b0;
                    retry_d   = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (core_idle) begin
                    send_req_d = 1'b1;
                    timer_d    = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // saturate so a scancode landing on the last cycle still lets the timeout fire next
                timer_d = (timer_q == T_LAST) ? timer_q : timer_q + 1'b1;
                if (is_ack) begin
                    if (!phase_q && has_arg_q) begin
                        phase_d = 1'b1;
                        retry_d = '0;
                        state_d = SEND;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 2'b00;
                        state_d = IDLE;
                    end
                end else if (is_nak || is_tmo) begin
                    if (retry_q < R_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = SEND;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = is_nak ? 2'b01 : 2'b10;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready      = state_q == IDLE;
    assign cmd_done       = done_q;
    assign cmd_err        = err_q;
    assign rx_vld         = rx_vld_q;
    assign rx_data        = rx_data_q;
    assign rx_parity_err  = rx_perr_q;
    assign core_send_req  = send_req_q;
    assign core_send_data = phase_q ? arg_q : cmd_q;
    assign core_hold_req  = hold_in && state_q == IDLE;
endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// tb_ps2_cmd_ctrl: directed scoreboard bench for ps2_cmd_ctrl with a scripted PS/2 device
module tb_ps2_cmd_ctrl;
    localparam int LIMIT = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       cmd_ready;
    logic       cmd_done;
    logic [1:0] cmd_err;
    logic       hold_in;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_vld;
    logic       core_send_req;
    logic [7:0] core_send_data;
    logic       core_hold_req;
    logic       core_idle;
    logic [7:0] core_rcv_data;
    logic       core_rcv_vld;
    logic       core_rcv_parity_err;

    ps2_cmd_ctrl #(.CLK(1), .TIMEOUT_MS(1), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_req(cmd_req), .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .hold_in(hold_in),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_vld(rx_vld),
        .core_send_req(core_send_req), .core_send_data(core_send_data), .core_hold_req(core_hold_req),
        .core_idle(core_idle), .core_rcv_data(core_rcv_data), .core_rcv_vld(core_rcv_vld),
        .core_rcv_parity_err(core_rcv_parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_sends = 0;
    logic [8:0] q_send[$];
    logic [8:0] q_rx[$];
    logic [2:0] q_done[$];
    logic [8:0] m_send, m_rx;
    logic [2:0] m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every DUT strobe pops its expectation; an empty queue yields a sentinel that never matches.
    always @(negedge clk) begin
        if (core_send_req) begin
            n_sends++;
            m_send = 9'h100;
            if (q_send.size() != 0) m_send = q_send.pop_front();
            check("send_data", {23'b0, 1'b0, core_send_data}, {23'b0, m_send});
        end
        if (rx_vld) begin
            m_rx = 9'h1FF;
            if (q_rx.size() != 0) m_rx = q_rx.pop_front();
            check("rx_byte", {23'b0, rx_parity_err, rx_data}, {23'b0, m_rx});
        end
        if (cmd_done) begin
            m_done = 3'b100;
            if (q_done.size() != 0) m_done = q_done.pop_front();
            check("done_err", {29'b0, 1'b0, cmd_err}, {29'b0, m_done});
            check("ready_with_done", {31'b0, cmd_ready}, 1);
        end
    end

    task automatic respond(input logic [7:0] d, input logic p);
        core_rcv_data       = d;
        core_rcv_parity_err = p;
        core_rcv_vld        = 1'b1;
        @(negedge clk);
        core_rcv_vld        = 1'b0;
    endtask

    task automatic issue(input logic [7:0] c, input logic h, input logic [7:0] a);
        cmd_byte    = c;
        cmd_has_arg = h;
        cmd_arg     = a;
        cmd_req     = 1'b1;
        @(negedge clk);
        cmd_req     = 1'b0;
        check("ready_drop", {31'b0, cmd_ready}, 0);
    endtask

    task automatic wait_send(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!core_send_req && n < 3 * LIMIT);
        check("send_seen", {31'b0, core_send_req}, 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_done && n < 3 * LIMIT);
        check("done_seen", {31'b0, cmd_done}, 1);
    endtask

    initial begin
        int n, s0;
        rst = 1'b0; hold_in = 1'b1; core_idle = 1'b1;
        cmd_req = 1'b0; cmd_byte = '0; cmd_has_arg = 1'b0; cmd_arg = '0;
        core_rcv_vld = 1'b0; core_rcv_data = '0; core_rcv_parity_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, cmd_ready}, 1);
        check("rst_done", {31'b0, cmd_done}, 0);
        check("rst_err", {30'b0, cmd_err}, 0);
        check("rst_rx_vld", {31'b0, rx_vld}, 0);
        check("rst_rx_data", {24'b0, rx_data}, 0);
        check("rst_rx_perr", {31'b0, rx_parity_err}, 0);
        check("rst_send_req", {31'b0, core_send_req}, 0);
        check("rst_send_data", {24'b0, core_send_data}, 0);
        check("rst_hold_hi", {31'b0, core_hold_req}, 1);
        hold_in = 1'b0;
        #1 check("rst_hold_lo", {31'b0, core_hold_req}, 0);
        rst = 1'b1;
        @(negedge clk);

        // single-byte 0xFF, ACKed
        s0 = n_sends;
        q_send.push_back(9'h0FF); q_done.push_back(3'd0);
        issue(8'hFF, 1'b0, 8'h00);
        wait_send(n);
        check("accept_to_send", n, 1);
        respond(8'hFA, 1'b0);
        check("done_latency", {31'b0, cmd_done}, 1);
        @(negedge clk);
        check("sends_ff", n_sends - s0, 1);

        // two-byte 0xED/0x07, core busy for a while first
        s0 = n_sends;
        q_send.push_back(9'h0ED); q_send.push_back(9'h007); q_done.push_back(3'd0);
        core_idle = 1'b0;
        issue(8'hED, 1'b1, 8'h07);
        repeat (3) @(negedge clk);
        check("idle_gate", n_sends - s0, 0);
        core_idle = 1'b1;
        wait_send(n);
        check("send_after_idle", n, 1);
        respond(8'hFA, 1'b0);
        wait_send(n);
        check("arg_send_lat", n, 1);
        respond(8'hFA, 1'b0);
        check("done_two_byte", {31'b0, cmd_done}, 1);
        @(negedge clk);
        check("sends_ed", n_sends - s0, 2);

        // resend recovery: 0xFE, then ACK with bad parity, then good ACK
        s0 = n_sends;
        repeat (3) q_send.push_back(9'h0F3);
        q_done.push_back(3'd0);
        issue(8'hF3, 1'b0, 8'h00);
        wait_send(n);
        respond(8'hFE, 1'b0);
        wait_send(n);
        respond(8'hFA, 1'b1);
        wait_send(n);
        respond(8'hFA, 1'b0);
        check("done_recover", {31'b0, cmd_done}, 1);
        @(negedge clk);
        check("sends_recover", n_sends - s0, 3);

        // resend exhaustion
        s0 = n_sends;
        repeat (4) q_send.push_back(9'h0F4);
        q_done.push_back(3'd1);
        issue(8'hF4, 1'b0, 8'h00);
        wait_send(n);
        repeat (3) begin
            respond(8'hFE, 1'b0);
            wait_send(n);
        end
        respond(8'hFE, 1'b0);
        check("done_exhaust", {31'b0, cmd_done}, 1);
        @(negedge clk);
        check("sends_exhaust", n_sends - s0, 4);

        // timeout, silent device; hold requested mid-command must be blocked
        s0 = n_sends;
        repeat (4) q_send.push_back(9'h0EE);
        q_done.push_back(3'd2);
        issue(8'hEE, 1'b0, 8'h00);
        wait_send(n);
        hold_in = 1'b1;
        #1 check("hold_blocked", {31'b0, core_hold_req}, 0);
        repeat (3) begin
            wait_send(n);
            check("tmo_gap", {31'b0, (n >= LIMIT && n <= LIMIT + 1)}, 1);
        end
        wait_done(n);
        check("tmo_done_lat", {31'b0, (n >= LIMIT && n <= LIMIT + 1)}, 1);
        check("hold_idle", {31'b0, core_hold_req}, 1);
        hold_in = 1'b0;
        repeat (3) @(negedge clk);
        check("err_held", {30'b0, cmd_err}, 2);
        check("sends_tmo", n_sends - s0, 4);

        // scancode between command and ACK, then IDLE passthrough
        q_send.push_back(9'h0FF); q_rx.push_back(9'h01C); q_done.push_back(3'd0);
        issue(8'hFF, 1'b0, 8'h00);
        wait_send(n);
        respond(8'h1C, 1'b0);
        check("scan_fwd", {31'b0, rx_vld}, 1);
        check("scan_no_done", {31'b0, cmd_done}, 0);
        check("scan_busy", {31'b0, cmd_ready}, 0);
        respond(8'hFA, 1'b0);
        check("done_scan", {31'b0, cmd_done}, 1);
        q_rx.push_back(9'h0F0);
        respond(8'hF0, 1'b0);
        check("idle_fwd", {31'b0, rx_vld}, 1);
        q_rx.push_back(9'h0FA);
        respond(8'hFA, 1'b0);
        check("idle_fa_no_done", {31'b0, cmd_done}, 0);
        q_rx.push_back(9'h1FE);
        respond(8'hFE, 1'b1);
        check("idle_perr_fwd", {31'b0, rx_vld}, 1);

        // accept and receive in the same IDLE cycle; a request while busy is ignored
        s0 = n_sends;
        q_send.push_back(9'h0F5); q_rx.push_back(9'h0AA); q_done.push_back(3'd0);
        cmd_byte = 8'hF5; cmd_has_arg = 1'b0; cmd_req = 1'b1;
        core_rcv_data = 8'hAA; core_rcv_parity_err = 1'b0; core_rcv_vld = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0; core_rcv_vld = 1'b0;
        check("both_rx", {31'b0, rx_vld}, 1);
        check("both_accept", {31'b0, cmd_ready}, 0);
        wait_send(n);
        cmd_byte = 8'h11; cmd_req = 1'b1;
        @(negedge clk);
        cmd_req = 1'b0;
        respond(8'hFA, 1'b0);
        check("done_both", {31'b0, cmd_done}, 1);
        repeat (4) @(negedge clk);
        check("sends_busy_ignored", n_sends - s0, 1);

        // reset mid-WAIT: no done, latched command gone
        q_send.push_back(9'h0F2);
        issue(8'hF2, 1'b0, 8'h00);
        wait_send(n);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstw_ready", {31'b0, cmd_ready}, 1);
        check("rstw_send_data", {24'b0, core_send_data}, 0);
        check("rstw_done", {31'b0, cmd_done}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        q_rx.push_back(9'h0FA);
        respond(8'hFA, 1'b0);
        check("post_rst_fwd", {31'b0, rx_vld}, 1);
        check("post_rst_no_done", {31'b0, cmd_done}, 0);
        repeat (3) @(negedge clk);

        check("q_send_empty", q_send.size(), 0);
        check("q_rx_empty", q_rx.size(), 0);
        check("q_done_empty", q_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
